serializer_buf: RTL and testbench
=================================

Name: serializer_buf

Overview:
Parametrised successor to the 8-bit serializer. Converts DATA_WIDTH-bit parallel words into a serial bit stream, with a selectable bit order per word. A one-word holding buffer with a valid/ready handshake lets the next word be queued while the current one shifts, so consecutive words go out back-to-back with no gap. Sits between a frame controller (parity/start/stop FSM) and the line driver, which advances it with SER_EN.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 2..32
IDLE_BIT, 1'b1, value driven on SER_DATA when no word is shifting

Ports:
CLK  in  1  clock; all state changes on the rising edge
RST  in  1  reset, asynchronous, active-low
P_DATA  in  DATA_WIDTH  parallel word, sampled on accept
DATA_VALID  in  1  producer has a word on P_DATA
DATA_READY  out  1  holding buffer empty; a word is accepted when DATA_VALID and DATA_READY are both 1 at a rising edge
MSB_FIRST  in  1  bit order, sampled with P_DATA on accept; 0 = LSB first, 1 = MSB first
SER_EN  in  1  shift strobe; the current bit is consumed at a rising edge where SER_EN=1
SER_DATA  out  1  current serial bit
SER_BUSY  out  1  word in the shifter (state SHIFT)
SER_DONE  out  1  one-cycle pulse after the last bit of a word is consumed

Behaviour:
- Storage: holding register (word, order bit, hold_valid); shift register (word, order bit); bit counter, CNT_W = clog2(DATA_WIDTH) bits; two-state FSM {IDLE, SHIFT}.
- Reset (asynchronous, RST=0):
  - hold_valid=0, shift register=0, counter=0, state=IDLE, SER_DONE=0.
  - Resulting outputs: DATA_READY=1, SER_BUSY=0, SER_DATA=IDLE_BIT.
  - Reset mid-word discards both the shifting word and the buffered word. No SER_DONE is produced for either.
- Ready and accept:
  - DATA_READY = !hold_valid, decoded from registers only; there is no combinational path from DATA_VALID.
  - On accept: hold register <= {MSB_FIRST, P_DATA}, hold_valid <= 1.
  - DATA_VALID while DATA_READY=0 is ignored; the producer holds its word.
- IDLE:
  - SER_DATA=IDLE_BIT, SER_BUSY=0. SER_EN is ignored.
  - If hold_valid=1: shift register <= hold, counter <= 0, hold_valid <= 0, state <= SHIFT.
  - Accept-to-first-bit latency: accept at edge N, load at edge N+1, bit 0 visible after edge N+1.
- SHIFT:
  - SER_BUSY=1.
  - SER_DATA = shift_reg[0] for LSB-first words, shift_reg[DATA_WIDTH-1] for MSB-first words. It is decoded from registers only.
  - SER_EN=1 with counter < DATA_WIDTH-1: shift one place toward the output end (right for LSB-first, left for MSB-first, zero fill), counter += 1.
  - SER_EN=1 with counter == DATA_WIDTH-1 (last bit): SER_DONE <= 1 for exactly one cycle.
    - If hold_valid=1: load hold into the shifter, counter <= 0, hold_valid <= 0, stay in SHIFT. The next word's bit 0 appears in the following cycle with no IDLE_BIT gap.
    - Else: state <= IDLE.
  - SER_EN=0: everything holds; stalls may be any length.
- Simultaneous events:
  - A hold-to-shifter transfer and a new accept cannot coincide, because DATA_READY=0 while hold_valid=1. The next accept is possible one cycle after the transfer.
  - A producer may accept the next word in the same cycle the shifter is busy; the buffer holds at most one pending word.
- DATA_VALID and SER_EN are each sampled only at the rising edge; there is no level-held behaviour beyond that.
- Counter never exceeds DATA_WIDTH-1; there is no wrap-around state.
- SER_DONE is a registered output, 0 in every cycle except the one following a last-bit consume.

Test Plan:
- Reset then idle: RST low for 2 cycles, then high, no stimulus -> DATA_READY=1, SER_BUSY=0, SER_DATA=1, SER_DONE=0 held for 20 cycles.
- LSB-first, continuous SER_EN=1: P_DATA=8'hA5, MSB_FIRST=0, accepted at edge 0 -> SER_DATA sequence 1,0,1,0,0,1,0,1 after edges 1..8; SER_DONE high for the single cycle after edge 9; SER_DATA=IDLE_BIT thereafter.
- MSB-first with stalls: P_DATA=8'hA5, MSB_FIRST=1, SER_EN toggled 1/0 -> bits 1,0,1,0,0,1,0,1 each held 2 cycles; exactly one SER_DONE pulse.
- Back-to-back words: accept 8'h0F (LSB-first), then accept 8'hF0 (MSB-first) while the first is busy -> DATA_READY=0 after the second accept; 16 contiguous bits 1111 0000 1111 0000; no IDLE_BIT gap; two SER_DONE pulses 8 SER_EN cycles apart.
- Backpressure: hold DATA_VALID=1 with words W1, W2, W3 while SER_EN=0 -> only W1 (shifting) and W2 (buffered) accepted; DATA_READY stays 0 until W1's last bit is consumed; W3 is not lost and is accepted afterwards.
- Reset mid-word with DATA_WIDTH=12: drop RST after 5 bits of 12'hABC while a word is buffered -> SER_BUSY=0, DATA_READY=1, SER_DATA=1 immediately; no SER_DONE; the buffered word is never emitted.

Source files
------------

// File: rtl/serializer_buf.sv
// Parallel-to-serial converter with per-word bit order and a one-word holding buffer.
// The buffered word moves into the shifter on the same edge the last bit leaves, so words go out back-to-back.
module serializer_buf #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_BIT   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  MSB_FIRST,
    input  logic                  SER_EN,
    output logic                  SER_DATA,
    output logic                  SER_BUSY,
    output logic                  SER_DONE
);
    localparam int              CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_msb;
    logic                  r_hold_vld;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_shift_msb;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;

    logic w_accept;
    logic w_last;
    logic w_load;

    // Accept and hold-to-shifter transfer are mutually exclusive: one needs hold empty, the other full.
    assign w_accept = DATA_VALID && !r_hold_vld;
    assign w_last   = (r_state == SHIFT) && SER_EN && (r_cnt == LAST);
    assign w_load   = r_hold_vld && ((r_state == IDLE) || w_last);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_hold_data <= '0;
            r_hold_msb  <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_shift     <= '0;
            r_shift_msb <= 1'b0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last;

            if (w_accept) begin
                r_hold_data <= P_DATA;
                r_hold_msb  <= MSB_FIRST;
                r_hold_vld  <= 1'b1;
            end else if (w_load) begin
                r_hold_vld  <= 1'b0;
            end

            if (w_load) begin
                r_shift     <= r_hold_data;
                r_shift_msb <= r_hold_msb;
                r_cnt       <= '0;
                r_state     <= SHIFT;
            end else if (w_last) begin
                r_state     <= IDLE;
            end else if ((r_state == SHIFT) && SER_EN) begin
                // Shift toward whichever end feeds SER_DATA for this word.
                r_shift <= r_shift_msb ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, r_shift[DATA_WIDTH-1:1]};
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign DATA_READY = !r_hold_vld;
    assign SER_BUSY   = (r_state == SHIFT);
    assign SER_DONE   = r_done;
    assign SER_DATA   = (r_state == SHIFT) ? (r_shift_msb ? r_shift[DATA_WIDTH-1] : r_shift[0])
                                           : IDLE_BIT;
endmodule

// File: tb/tb_serializer_buf.sv
// Directed bench for serializer_buf: expected serial bits are queued on accept and
// popped by a monitor each time the DUT consumes a bit.
module tb_serializer_buf;
    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID, MSB_FIRST, SER_EN;
    logic       DATA_READY, SER_DATA, SER_BUSY, SER_DONE;

    logic        RST12;
    logic [11:0] P_DATA12;
    logic        DV12, MSB12, EN12;
    logic        READY12, SER_DATA12, BUSY12, DONE12;

    always #5 CLK = ~CLK;

    serializer_buf #(.DATA_WIDTH(8), .IDLE_BIT(1'b1)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .MSB_FIRST(MSB_FIRST), .SER_EN(SER_EN),
        .SER_DATA(SER_DATA), .SER_BUSY(SER_BUSY), .SER_DONE(SER_DONE)
    );

    serializer_buf #(.DATA_WIDTH(12), .IDLE_BIT(1'b1)) dut12 (
        .CLK(CLK), .RST(RST12), .P_DATA(P_DATA12), .DATA_VALID(DV12),
        .DATA_READY(READY12), .MSB_FIRST(MSB12), .SER_EN(EN12),
        .SER_DATA(SER_DATA12), .SER_BUSY(BUSY12), .SER_DONE(DONE12)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic exp_q[$];
    int   done_cyc[$];

    always @(posedge CLK) cyc++;

    // Scoreboard monitor: a bit is consumed at the next rising edge when busy and SER_EN are high.
    always @(negedge CLK) begin
        logic expv;
        if (RST === 1'b1) begin
            if (SER_BUSY && SER_EN) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL serbit: got %0b with no expected bit queued", SER_DATA);
                end else begin
                    expv = exp_q.pop_front();
                    assert (SER_DATA === expv) else begin
                        errors++;
                        $error("FAIL serbit: got %0b expected %0b (cycle %0d)", SER_DATA, expv, cyc);
                    end
                end
            end
            if (SER_DONE === 1'b1) done_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [7:0] w, input logic msb);
        for (int i = 0; i < 8; i++) exp_q.push_back(msb ? w[7-i] : w[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, d0;
        logic       flag;
        logic [7:0] wv;
        logic [11:0] wv12;

        RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; MSB_FIRST = 1'b0; SER_EN = 1'b0;
        RST12 = 1'b0; P_DATA12 = '0; DV12 = 1'b0; MSB12 = 1'b0; EN12 = 1'b0;

        // Reset then idle
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", DATA_READY, 1); chk("rst_busy", SER_BUSY, 0);
        chk("rst_data", SER_DATA, 1);    chk("rst_done", SER_DONE, 0);
        RST = 1'b1; RST12 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_ready", DATA_READY, 1); chk("idle_busy", SER_BUSY, 0);
            chk("idle_data", SER_DATA, 1);    chk("idle_done", SER_DONE, 0);
        end

        // LSB-first, continuous SER_EN
        P_DATA = 8'hA5; MSB_FIRST = 1'b0; DATA_VALID = 1'b1; SER_EN = 1'b1;
        push_word(8'hA5, 1'b0);
        step(); DATA_VALID = 1'b0;
        chk("lsb_ready_held", DATA_READY, 0); chk("lsb_not_busy_yet", SER_BUSY, 0);
        step();
        chk("lsb_busy", SER_BUSY, 1); chk("lsb_bit0", SER_DATA, 1);
        repeat (7) step();
        chk("lsb_busy_last", SER_BUSY, 1); chk("lsb_no_early_done", SER_DONE, 0);
        step();
        chk("lsb_idle", SER_BUSY, 0); chk("lsb_done", SER_DONE, 1); chk("lsb_idle_bit", SER_DATA, 1);
        step();
        chk("lsb_done_pulse", SER_DONE, 0); chk("lsb_idle_bit2", SER_DATA, 1);
        chk("lsb_q_empty", exp_q.size(), 0);
        SER_EN = 1'b0;

        // MSB-first with stalls
        d0 = done_cyc.size();
        wv = 8'hA5;
        P_DATA = wv; MSB_FIRST = 1'b1; DATA_VALID = 1'b1;
        push_word(wv, 1'b1);
        step(); DATA_VALID = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            SER_EN = 1'b0; step();
            chk("msb_stall_hold", SER_DATA, wv[7-i]);
            chk("msb_stall_no_done", SER_DONE, 0);
            SER_EN = 1'b1; step();
        end
        SER_EN = 1'b0;
        chk("msb_idle", SER_BUSY, 0); chk("msb_done", SER_DONE, 1);
        step();
        chk("msb_done_pulse", SER_DONE, 0);
        chk("msb_done_count", done_cyc.size(), d0 + 1);
        chk("msb_q_empty", exp_q.size(), 0);

        // Back-to-back words, no gap
        d0 = done_cyc.size();
        SER_EN = 1'b1;
        P_DATA = 8'h0F; MSB_FIRST = 1'b0; DATA_VALID = 1'b1;
        push_word(8'h0F, 1'b0);
        step();
        P_DATA = 8'hF0; MSB_FIRST = 1'b1;
        push_word(8'hF0, 1'b1);
        n = 0;
        while (!DATA_READY && n < 20) begin step(); n++; end
        chk("b2b_ready_timeout", n < 20, 1);
        step(); DATA_VALID = 1'b0;
        chk("b2b_ready_full", DATA_READY, 0);
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (SER_BUSY !== 1'b1) flag = 1'b1;
            step();
        end
        chk("b2b_no_gap", flag, 0);
        chk("b2b_idle", SER_BUSY, 0); chk("b2b_done2", SER_DONE, 1);
        SER_EN = 1'b0;
        step();
        chk("b2b_q_empty", exp_q.size(), 0);
        chk("b2b_done_count", done_cyc.size(), d0 + 2);
        if (done_cyc.size() >= d0 + 2)
            chk("b2b_done_spacing", done_cyc[d0+1] - done_cyc[d0], 8);

        // Backpressure: W1 shifting, W2 buffered, W3 waits
        d0 = done_cyc.size();
        P_DATA = 8'h3C; MSB_FIRST = 1'b0; DATA_VALID = 1'b1;
        push_word(8'h3C, 1'b0);
        step();
        P_DATA = 8'h96; MSB_FIRST = 1'b1;
        push_word(8'h96, 1'b1);
        step(); step();
        P_DATA = 8'h5A; MSB_FIRST = 1'b0;
        chk("bp_w2_buffered", DATA_READY, 0);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (DATA_READY !== 1'b0 || SER_BUSY !== 1'b1) flag = 1'b1;
        end
        chk("bp_ready_held", flag, 0);
        SER_EN = 1'b1;
        repeat (7) step();
        chk("bp_ready_before_last", DATA_READY, 0);
        step();
        chk("bp_ready_after_last", DATA_READY, 1); chk("bp_busy_w2", SER_BUSY, 1);
        push_word(8'h5A, 1'b0);
        step(); DATA_VALID = 1'b0;
        chk("bp_w3_accepted", DATA_READY, 0);
        n = 0;
        while (SER_BUSY && n < 40) begin step(); n++; end
        chk("bp_drain_timeout", n < 40, 1);
        SER_EN = 1'b0;
        step();
        chk("bp_q_empty", exp_q.size(), 0);
        chk("bp_done_count", done_cyc.size(), d0 + 3);

        // Reset mid-word on the 12-bit instance
        wv12 = 12'hABC;
        P_DATA12 = wv12; MSB12 = 1'b0; DV12 = 1'b1; EN12 = 1'b1;
        step();
        P_DATA12 = 12'h123;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("r12_bit", SER_DATA12, wv12[i]);
            step();
        end
        DV12 = 1'b0;
        chk("r12_buffered", READY12, 0); chk("r12_busy", BUSY12, 1);
        chk("r12_bit5", SER_DATA12, wv12[5]);
        RST12 = 1'b0;
        #1;
        chk("r12_rst_busy", BUSY12, 0); chk("r12_rst_ready", READY12, 1);
        chk("r12_rst_data", SER_DATA12, 1); chk("r12_rst_done", DONE12, 0);
        step();
        RST12 = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (BUSY12 !== 1'b0 || DONE12 !== 1'b0 || SER_DATA12 !== 1'b1) flag = 1'b1;
        end
        chk("r12_discarded", flag, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
